// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_pkg
// Description : Shared types and sizes for the register file write-back arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_arbiter_pkg;

    localparam int REG_SIZE   = 32;
    localparam int NUM_WPORTS = 2;
    localparam int REQ_IDX_W  = 3;

    typedef logic [4:0]           regaddr_t;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter_rr_pick
// Description : Rotating-priority first-one finder with an exclude mask
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter_rr_pick
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  req_idx_t     start,
    input  logic [N-1:0] exclude,
    output logic [N-1:0] grant,
    output req_idx_t     idx,
    output logic         found
);

    logic [N-1:0] w_cand;

    assign w_cand = req & ~exclude;

    // Walk candidates in order start, start+1, ... wrapping at N.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && w_cand[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = req_idx_t'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Round-robin write-back arbiter feeding a 2-write-port regfile
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int XLEN  = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic     [N_REQ-1:0]                req_valid,
    input  regaddr_t [N_REQ-1:0]                req_wa,
    input  logic     [N_REQ-1:0][XLEN-1:0]      req_wd,
    output logic     [N_REQ-1:0]                req_ready,
    output regaddr_t [NUM_WPORTS-1:0]           wa,
    output logic     [NUM_WPORTS-1:0][XLEN-1:0] wd,
    output logic     [REG_SIZE-1:0]             wb_busy
);

    logic [N_REQ-1:0] w_nz;
    logic [N_REQ-1:0] w_zero;
    logic [N_REQ-1:0] w_same;
    logic [N_REQ-1:0] w_gnt0;
    logic [N_REQ-1:0] w_gnt1;
    req_idx_t         r_ptr;
    req_idx_t         w_idx0;
    req_idx_t         w_idx1;
    req_idx_t         w_last;
    req_idx_t         w_ptr_nxt;
    logic             w_found0;
    logic             w_found1;
    regaddr_t         w_wa0;
    regaddr_t         w_wa1;
    logic [XLEN-1:0]  w_wd0;
    logic [XLEN-1:0]  w_wd1;

    always_comb begin
        w_nz   = '0;
        w_zero = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_nz[i]   = req_valid[i] && (req_wa[i] != '0);
            w_zero[i] = req_valid[i] && (req_wa[i] == '0);
        end
    end

    regfile_wr_arbiter_rr_pick #(.N(N_REQ)) u_pick0 (
        .req     (w_nz),
        .start   (r_ptr),
        .exclude ('0),
        .grant   (w_gnt0),
        .idx     (w_idx0),
        .found   (w_found0)
    );

    always_comb begin
        w_wa0 = '0;
        w_wd0 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt0[i]) begin
                w_wa0 = req_wa[i];
                w_wd0 = req_wd[i];
            end
        end
    end

    // Masking every requester aimed at slot 0's register also removes the slot-0 winner.
    always_comb begin
        w_same = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_same[i] = w_found0 && (req_wa[i] == w_wa0);
        end
    end

    regfile_wr_arbiter_rr_pick #(.N(N_REQ)) u_pick1 (
        .req     (w_nz),
        .start   (r_ptr),
        .exclude (w_same),
        .grant   (w_gnt1),
        .idx     (w_idx1),
        .found   (w_found1)
    );

    always_comb begin
        w_wa1 = '0;
        w_wd1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt1[i]) begin
                w_wa1 = req_wa[i];
                w_wd1 = req_wd[i];
            end
        end
    end

    assign req_ready = stall ? '0 : (w_zero | w_gnt0 | w_gnt1);

    assign w_last    = w_found1 ? w_idx1 : w_idx0;
    assign w_ptr_nxt = (int'(w_last) == N_REQ - 1) ? '0 : w_last + req_idx_t'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            wa    <= '0;
            wd    <= '0;
        end else begin
            if (!stall && w_found0) begin
                r_ptr <= w_ptr_nxt;
            end
            if (stall) begin
                wa <= '0;
                wd <= '0;
            end else begin
                wa <= {w_wa1, w_wa0};
                wd <= {w_wd1, w_wd0};
            end
        end
    end

    always_comb begin
        wb_busy = '0;
        for (int r = 1; r < REG_SIZE; r++) begin
            for (int k = 0; k < NUM_WPORTS; k++) begin
                if (wa[k] == regaddr_t'(r)) begin
                    wb_busy[r] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed plus randomized bench for regfile_wr_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int N    = 4;
    localparam int XLEN = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     stall = 1'b0;
    logic [N-1:0]             req_valid;
    logic [N-1:0][4:0]        req_wa;
    logic [N-1:0][XLEN-1:0]   req_wd;
    logic [N-1:0]             req_ready;
    logic [1:0][4:0]          wa;
    logic [1:0][XLEN-1:0]     wd;
    logic [31:0]              wb_busy;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.N_REQ(N), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .wa        (wa),
        .wd        (wd),
        .wb_busy   (wb_busy)
    );

    int checks = 0;
    int errors = 0;

    // Requester state and reference model state
    logic        v [N];
    logic [4:0]  a [N];
    logic [31:0] d [N];
    logic        st;
    int          m_ptr;
    logic [4:0]  m_wa [2];
    logic [31:0] m_wd [2];
    int          n_ptr;
    logic [4:0]  n_wa [2];
    logic [31:0] n_wd [2];
    logic [N-1:0] exp_rdy;
    logic [31:0] rf [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model();
        int slots[$];
        exp_rdy = '0;
        n_ptr   = m_ptr;
        n_wa    = '{5'd0, 5'd0};
        n_wd    = '{32'd0, 32'd0};
        if (!st) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!v[i]) continue;
                if (a[i] == 5'd0) begin
                    exp_rdy[i] = 1'b1;
                end else if (slots.size() == 0 ||
                             (slots.size() == 1 && a[i] != a[slots[0]])) begin
                    slots.push_back(i);
                    exp_rdy[i] = 1'b1;
                end
            end
            foreach (slots[s]) begin
                n_wa[s] = a[slots[s]];
                n_wd[s] = d[slots[s]];
            end
            if (slots.size() > 0) n_ptr = (slots[$] + 1) % N;
        end
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        b = '0;
        if (m_wa[0] != 5'd0) b[m_wa[0]] = 1'b1;
        if (m_wa[1] != 5'd0) b[m_wa[1]] = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = v[i];
            req_wa[i]    = a[i];
            req_wd[i]    = d[i];
        end
        stall = st;
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        drive();
        model();
        #1;
        chk({tag, " ready"}, 64'(req_ready), 64'(exp_rdy));
        if (wa[0] != 5'd0) rf[wa[0]] = wd[0];
        if (wa[1] != 5'd0) rf[wa[1]] = wd[1];
    endtask

    task automatic commit(input string tag, input bit retire);
        @(posedge clk);
        #1;
        m_wa  = n_wa;
        m_wd  = n_wd;
        m_ptr = n_ptr;
        chk({tag, " wa0"}, 64'(wa[0]), 64'(m_wa[0]));
        chk({tag, " wa1"}, 64'(wa[1]), 64'(m_wa[1]));
        chk({tag, " wd0"}, 64'(wd[0]), 64'(m_wd[0]));
        chk({tag, " wd1"}, 64'(wd[1]), 64'(m_wd[1]));
        chk({tag, " busy"}, 64'(wb_busy), 64'(exp_busy()));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                if (retire) v[i] = 1'b0;
                d[i] = $urandom;
            end
        end
    endtask

    task automatic step(input string tag, input bit retire);
        settle(tag);
        commit(tag, retire);
    endtask

    initial begin
        int i0;
        int i1;
        st    = 1'b0;
        m_ptr = 0;
        m_wa  = '{5'd0, 5'd0};
        m_wd  = '{32'd0, 32'd0};
        for (int r = 0; r < 32; r++) rf[r] = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            a[i] = 5'(i + 1);
            d[i] = $urandom;
        end

        // Held in reset: ready still responds with pointer 0
        settle("rst");
        chk("rst ready const", 64'(req_ready), 64'(4'b0011));
        chk("rst wa", 64'(wa), 64'(0));
        chk("rst busy", 64'(wb_busy), 64'(0));
        @(posedge clk);
        #1;
        chk("rst hold wa", 64'(wa), 64'(0));
        settle("rst2");
        reset = 1'b1;
        commit("first", 1'b0);
        chk("first grant", 64'(wa), 64'({5'd2, 5'd1}));

        for (int c = 0; c < 3; c++) step("rr", 1'b0);
        for (int i = 0; i < N; i++) v[i] = 1'b0;

        // Destination conflict
        v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hA;
        v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'hB;
        v[2] = 1'b1; a[2] = 5'd6; d[2] = 32'hC;
        step("conf", 1'b1);
        chk("conf wa const", 64'(wa), 64'({5'd6, 5'd5}));
        step("conf2", 1'b1);
        chk("conf2 wd const", 64'(wd[0]), 64'(32'hB));
        step("idle", 1'b1);
        step("idle", 1'b1);
        chk("rf x5", 64'(rf[5]), 64'(32'hB));
        chk("rf x6", 64'(rf[6]), 64'(32'hC));

        // x0 sink
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = 5'd0; d[i] = $urandom;
        end
        step("x0", 1'b1);
        chk("x0 wa const", 64'(wa), 64'(0));

        // Stall then resume from unchanged pointer (2)
        v[0] = 1'b1; a[0] = 5'd8;
        v[1] = 1'b1; a[1] = 5'd9;
        v[2] = 1'b1; a[2] = 5'd10;
        st = 1'b1;
        step("stall", 1'b1);
        step("stall", 1'b1);
        st = 1'b0;
        step("resume", 1'b1);
        chk("resume wa const", 64'(wa), 64'({5'd8, 5'd10}));
        step("resume2", 1'b1);

        // Randomized traffic with conflicts, x0 and stalls
        for (int c = 0; c < 400; c++) begin
            st = ($urandom_range(7) == 0);
            step("rand", 1'b1);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(2) != 0) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom_range(7));
                    d[i] = $urandom;
                end
            end
        end

        // Asynchronous reset while outputs carry {7,9}
        st = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        i0 = m_ptr;
        i1 = (m_ptr + 1) % N;
        v[i0] = 1'b1; a[i0] = 5'd7; d[i0] = $urandom;
        v[i1] = 1'b1; a[i1] = 5'd9; d[i1] = $urandom;
        step("pre_rst", 1'b1);
        chk("pre_rst wa const", 64'(wa), 64'({5'd9, 5'd7}));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst wa", 64'(wa), 64'(0));
        chk("mid_rst wd", 64'(wd), 64'(0));
        chk("mid_rst busy", 64'(wb_busy), 64'(0));
        m_ptr = 0;
        m_wa  = '{5'd0, 5'd0};
        m_wd  = '{32'd0, 32'd0};
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = 5'(i + 11); d[i] = $urandom;
        end
        settle("mid_rst");
        chk("mid_rst ptr0", 64'(req_ready), 64'(4'b0011));
        reset = 1'b1;
        commit("post_rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
